generic_fifo_sc: RTL and testbench

Single-clock, parameterised synchronous FIFO with registered read data, exact-count status flags and programmable near-full/near-empty thresholds. It buffers byte-wide (default) data between a producer and a consumer in the same clock domain and exposes both combinational-style and flop-driven flag copies so callers can pick the timing they need.

---
 rtl/generic_fifo_sc.sv | 116 +++++++++++
 tb/tb_generic_fifo_sc.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/generic_fifo_sc.sv
// Single-clock FIFO with registered read data, exact-count flags and
// programmable near-full/near-empty thresholds, each flag also offered as a flop output.
module generic_fifo_sc #(
  parameter int dw = 8,
  parameter int aw = 8,
  parameter int n  = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [dw-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [dw-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          full_r,
  output logic          empty_r,
  output logic          full_n,
  output logic          empty_n,
  output logic          full_n_r,
  output logic          empty_n_r,
  output logic [1:0]    level
);

  localparam int unsigned DepthI     = 1 << aw;
  localparam int unsigned FullNThrI  = DepthI - n + 1;
  localparam int unsigned EmptyNThrI = n;
  localparam int unsigned Q1I        = DepthI / 4;
  localparam int unsigned Q2I        = DepthI / 2;
  localparam int unsigned Q3I        = (3 * DepthI) / 4;

  localparam logic [aw:0] Depth     = DepthI[aw:0];
  localparam logic [aw:0] FullNThr  = FullNThrI[aw:0];
  localparam logic [aw:0] EmptyNThr = EmptyNThrI[aw:0];
  localparam logic [aw:0] Q1        = Q1I[aw:0];
  localparam logic [aw:0] Q2        = Q2I[aw:0];
  localparam logic [aw:0] Q3        = Q3I[aw:0];

  logic [dw-1:0] mem [DepthI];

  logic [aw-1:0] wp_q, wp_d;
  logic [aw-1:0] rp_q, rp_d;
  logic [aw:0]   cnt_q, cnt_d;
  logic [dw-1:0] dout_q;
  logic          full_r_q, empty_r_q, full_n_r_q, empty_n_r_q;
  logic          wr_en, rd_en;

  // clr wins over same-cycle requests, so neither pointer nor memory moves
  always_comb begin
    wr_en = we & ~full  & ~clr;
    rd_en = re & ~empty & ~clr;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_en) wp_d = wp_q + aw'(1);
      if (rd_en) rp_d = rp_q + aw'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + (aw+1)'(1);
        2'b01:   cnt_d = cnt_q - (aw+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q] <= din;
  end

  // Flop flag copies are computed from the next count so they match the
  // count-derived flags in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      full_r_q    <= 1'b0;
      empty_r_q   <= 1'b1;
      full_n_r_q  <= 1'b0;
      empty_n_r_q <= 1'b1;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      if (rd_en) dout_q <= mem[rp_q];
      full_r_q    <= (cnt_d == Depth);
      empty_r_q   <= (cnt_d == '0);
      full_n_r_q  <= (cnt_d >= FullNThr);
      empty_n_r_q <= (cnt_d < EmptyNThr);
    end
  end

  always_comb begin
    level = 2'd0;
    if (cnt_q >= Q3)      level = 2'd3;
    else if (cnt_q >= Q2) level = 2'd2;
    else if (cnt_q >= Q1) level = 2'd1;
  end

  assign dout      = dout_q;
  assign full      = (cnt_q == Depth);
  assign empty     = (cnt_q == '0);
  assign full_n    = (cnt_q >= FullNThr);
  assign empty_n   = (cnt_q < EmptyNThr);
  assign full_r    = full_r_q;
  assign empty_r   = empty_r_q;
  assign full_n_r  = full_n_r_q;
  assign empty_n_r = empty_n_r_q;

endmodule

// File: tb/tb_generic_fifo_sc.sv
// Self-checking bench for generic_fifo_sc: directed and random traffic
// compared against a queue-based reference model.
module tb_generic_fifo_sc;

  localparam int Depth = 256;
  localparam int NThr  = 9;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [7:0] din;
  logic       we;
  logic       re;
  logic [7:0] dout;
  logic       full, empty, full_r, empty_r;
  logic       full_n, empty_n, full_n_r, empty_n_r;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0] modelQ [$];
  logic [7:0] modelDout;

  generic_fifo_sc #(.dw(8), .aw(8), .n(NThr)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
    .dout(dout), .full(full), .empty(empty), .full_r(full_r), .empty_r(empty_r),
    .full_n(full_n), .empty_n(empty_n), .full_n_r(full_n_r), .empty_n_r(empty_n_r),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected flags come straight from the occupancy of the reference queue
  task automatic checkAll(input string where);
    int cnt;
    int lvl;
    cnt = modelQ.size();
    lvl = (cnt * 4) / Depth;
    if (lvl > 3) lvl = 3;
    checkOutput({where, ".dout"},      32'(dout),      32'(modelDout));
    checkOutput({where, ".full"},      32'(full),      32'(cnt == Depth));
    checkOutput({where, ".empty"},     32'(empty),     32'(cnt == 0));
    checkOutput({where, ".full_r"},    32'(full_r),    32'(cnt == Depth));
    checkOutput({where, ".empty_r"},   32'(empty_r),   32'(cnt == 0));
    checkOutput({where, ".full_n"},    32'(full_n),    32'(Depth - cnt < NThr));
    checkOutput({where, ".empty_n"},   32'(empty_n),   32'(cnt < NThr));
    checkOutput({where, ".full_n_r"},  32'(full_n_r),  32'(Depth - cnt < NThr));
    checkOutput({where, ".empty_n_r"}, 32'(empty_n_r), 32'(cnt < NThr));
    checkOutput({where, ".level"},     32'(level),     32'(lvl));
  endtask

  task automatic applyStimulus(input string where, input logic w, input logic r,
                               input logic c, input logic [7:0] d);
    logic canWr, canRd;
    we  = w;
    re  = r;
    clr = c;
    din = d;
    @(posedge clk);
    canWr = w && (modelQ.size() < Depth);
    canRd = r && (modelQ.size() > 0);
    if (c) begin
      modelQ.delete();
    end else begin
      if (canRd) modelDout = modelQ.pop_front();
      if (canWr) modelQ.push_back(d);
    end
    #1;
    checkAll(where);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;
    modelDout = 8'h00;
    #1;
    checkAll("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus("underflow0", 1'b0, 1'b1, 1'b0, 8'h11);

    applyStimulus("single.wr", 1'b1, 1'b0, 1'b0, 8'hA5);
    applyStimulus("single.rd", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 4; i++) applyStimulus("burst.wr", 1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 4; i++) applyStimulus("burst.rd", 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("gap.wr", 1'b1, 1'b0, 1'b0, 8'($urandom));
      applyStimulus("gap.idle", 1'b0, 1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus("gap.rd", 1'b0, 1'b1, 1'b0, 8'h00);
      applyStimulus("gap.idle", 1'b0, 1'b0, 1'b0, 8'h00);
    end

    // Fill completely; every threshold crossing is checked along the way
    for (int i = 0; i < Depth; i++) applyStimulus("fill", 1'b1, 1'b0, 1'b0, 8'($urandom));
    applyStimulus("overflow", 1'b1, 1'b0, 1'b0, 8'hEE);
    applyStimulus("full.wr_rd", 1'b1, 1'b1, 1'b0, 8'hDD);
    for (int i = 0; i < 100; i++) applyStimulus("drain.part", 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 101; i++) applyStimulus("refill.wrap", 1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < Depth + 2; i++) applyStimulus("drain.all", 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus("empty.wr_rd", 1'b1, 1'b1, 1'b0, 8'h77);
    applyStimulus("underflow1", 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus("underflow2", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i < 300) ? 70 : 30;
      applyStimulus("random", 1'($urandom_range(0, 99) < bias),
                    1'($urandom_range(0, 99) >= bias), 1'b0, 8'($urandom));
    end

    for (int i = 0; i < 10; i++) applyStimulus("clr.fill", 1'b1, 1'b0, 1'b0, 8'($urandom));
    applyStimulus("clr", 1'b1, 1'b1, 1'b1, 8'h99);
    applyStimulus("clr.wr", 1'b1, 1'b0, 1'b0, 8'h3C);
    applyStimulus("clr.rd", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 5; i++) applyStimulus("rst.fill", 1'b1, 1'b0, 1'b0, 8'($urandom));
    we = 1'b0;
    #2 rst = 1'b1;
    modelQ.delete();
    modelDout = 8'h00;
    #1;
    checkAll("rst.async");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("rst.rd", 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus("rst.wr", 1'b1, 1'b0, 1'b0, 8'h5A);
    applyStimulus("rst.rd2", 1'b0, 1'b1, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
